// File: rtl/hazard_controller_n.sv
// Pipeline hazard controller: per-register stall/purge vectors for branch flush,
// load-use bubbles, multi-cycle EX ops and memory wait. Optional stats: HAZARD_STATS_EN.
module hazard_controller_n #(
  parameter int STAGES        = 5,
  parameter int BRANCH_STAGE  = 3,
  parameter int LOADUSE_STAGE = 2,
  parameter int MULTI_STAGE   = 2,
  parameter int CNT_W         = 4
) (
  input  logic              ClockInput,
  input  logic              ResetInput_n,
  input  logic              BranchSignal,
  input  logic              FwdStallRequest,
  input  logic              MultiStart,
  input  logic [CNT_W-1:0]  MultiLen,
  input  logic              MemHold,
  output logic [STAGES-1:0] StallVector,
  output logic [STAGES-1:0] PurgeVector,
  output logic              MultiBusy,
  output logic [1:0]        HazState
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       StallCycles,
  output logic [15:0]       FlushCount
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_MULTI = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  function automatic logic [STAGES-1:0] f_mask(input int lo, input int hi);
    logic [STAGES-1:0] m;
    m = '0;
    for (int k = 0; k < STAGES; k++)
      if (k >= lo && k <= hi) m[k] = 1'b1;
    return m;
  endfunction

  localparam logic [STAGES-1:0] BR_PURGE = f_mask(1, BRANCH_STAGE);
  localparam logic [STAGES-1:0] LU_STALL = f_mask(0, LOADUSE_STAGE - 1);
  localparam logic [STAGES-1:0] LU_PURGE = f_mask(LOADUSE_STAGE, LOADUSE_STAGE);
  localparam logic [STAGES-1:0] MU_STALL = f_mask(0, MULTI_STAGE);
  localparam logic [STAGES-1:0] MU_PURGE = f_mask(MULTI_STAGE + 1, MULTI_STAGE + 1);

  generate
    if (BRANCH_STAGE >= STAGES || LOADUSE_STAGE >= STAGES || MULTI_STAGE + 1 >= STAGES) begin : g_bad_cfg
      $error("hazard_controller_n: stage parameter out of range for STAGES");
    end
  endgenerate

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_dec;
  logic [STAGES-1:0]  r_stall, r_purge, w_stall_nxt, w_purge_nxt;
  logic               r_busy;

  assign w_dec = r_cnt - CNT_W'(1);

  // A multi-cycle op stays alive through HOLD via a nonzero counter; the edge
  // on which the counter reaches zero releases the pipe without new requests.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_cnt_nxt   = r_cnt;
    w_stall_nxt = '0;
    w_purge_nxt = '0;
    if (BranchSignal) begin
      w_state_nxt = S_FLUSH;
      w_purge_nxt = BR_PURGE;
      w_cnt_nxt   = '0;
    end else if (MemHold) begin
      w_state_nxt = S_HOLD;
      w_stall_nxt = '1;
    end else if (r_state == S_MULTI || (r_state == S_HOLD && r_cnt != '0)) begin
      w_cnt_nxt = w_dec;
      if (w_dec != '0) begin
        w_state_nxt = S_MULTI;
        w_stall_nxt = MU_STALL;
        w_purge_nxt = MU_PURGE;
      end
    end else if (r_state == S_HOLD) begin
      w_state_nxt = S_IDLE;
    end else if (MultiStart && MultiLen != '0) begin
      w_state_nxt = S_MULTI;
      w_cnt_nxt   = MultiLen;
      w_stall_nxt = MU_STALL;
      w_purge_nxt = MU_PURGE;
    end else if (FwdStallRequest) begin
      w_stall_nxt = LU_STALL;
      w_purge_nxt = LU_PURGE;
    end
  end

  always_ff @(negedge ClockInput or negedge ResetInput_n) begin
    if (!ResetInput_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stall <= '0;
      r_purge <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stall <= w_stall_nxt;
      r_purge <= w_purge_nxt & ~w_stall_nxt;
      r_busy  <= (w_state_nxt == S_MULTI);
    end
  end

  assign StallVector = r_stall;
  assign PurgeVector = r_purge;
  assign MultiBusy   = r_busy;
  assign HazState    = r_state;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cyc, r_flush_cnt;

  always_ff @(negedge ClockInput or negedge ResetInput_n) begin
    if (!ResetInput_n) begin
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_nxt != '0 && r_stall_cyc != 16'hFFFF) r_stall_cyc <= r_stall_cyc + 16'd1;
      if (BranchSignal && r_flush_cnt != 16'hFFFF)     r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign StallCycles = r_stall_cyc;
  assign FlushCount  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller_n.sv
// Scoreboard bench for hazard_controller_n: expected output words are queued per
// driven cycle and compared after the DUT's falling-edge update.
module tb_hazard_controller_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       br = 1'b0, fwd = 1'b0, ms = 1'b0, mh = 1'b0;
  logic [3:0] ml = 4'd0;
  logic [4:0] stall, purge;
  logic       busy;
  logic [1:0] hst;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cyc, flush_cnt;
`endif

  hazard_controller_n dut (
    .ClockInput      (clk),
    .ResetInput_n    (rst_n),
    .BranchSignal    (br),
    .FwdStallRequest (fwd),
    .MultiStart      (ms),
    .MultiLen        (ml),
    .MemHold         (mh),
    .StallVector     (stall),
    .PurgeVector     (purge),
    .MultiBusy       (busy),
    .HazState        (hst)
`ifdef HAZARD_STATS_EN
    ,
    .StallCycles     (stall_cyc),
    .FlushCount      (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {busy, state, stall, purge}
  localparam logic [12:0] E_IDLE  = {1'b0, 2'd0, 5'b00000, 5'b00000};
  localparam logic [12:0] E_FLUSH = {1'b0, 2'd1, 5'b00000, 5'b01110};
  localparam logic [12:0] E_FWD   = {1'b0, 2'd0, 5'b00011, 5'b00100};
  localparam logic [12:0] E_MULTI = {1'b1, 2'd2, 5'b00111, 5'b01000};
  localparam logic [12:0] E_HOLD  = {1'b0, 2'd3, 5'b11111, 5'b00000};

  typedef struct packed {
    logic       br, fwd, ms;
    logic [3:0] ml;
    logic       mh;
    logic [12:0] e;
  } row_t;

  logic [12:0] sb[$];
  int checks = 0, errors = 0;

  function automatic row_t R(input logic b, f, s, input logic [3:0] l, input logic h, input logic [12:0] e);
    R = '{br: b, fwd: f, ms: s, ml: l, mh: h, e: e};
  endfunction

  // Drive one row on the rising edge, queue its expectation, then wait past the falling edge.
  task automatic cyc(input row_t r);
    @(posedge clk); #1;
    br = r.br; fwd = r.fwd; ms = r.ms; ml = r.ml; mh = r.mh;
    sb.push_back(r.e);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    br = 0; fwd = 0; ms = 0; ml = 0; mh = 0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] act;
    row_t rows[3];
    #2 rst_n = 1'b0;
    #1 act = {busy, hst, stall, purge};
    checks++;
    if (act !== E_IDLE) begin errors++; $display("FAIL reset_init: got %h expected %h", act, E_IDLE); end
    #2 rst_n = 1'b1;
    rows = '{R(0,0,1,4'd5,0,E_MULTI), R(0,0,0,4'd0,0,E_MULTI), R(0,0,0,4'd0,0,E_MULTI)};
    foreach (rows[i]) begin
      cyc(rows[i]);
      act = {busy, hst, stall, purge};
      checks++;
      if (act !== sb.pop_front()) begin errors++; $display("FAIL reset_pre[%0d]: got %h expected %h", i, act, rows[i].e); end
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 act = {busy, hst, stall, purge};
    checks++;
    if (act !== E_IDLE) begin errors++; $display("FAIL reset_mid_multi: got %h expected %h", act, E_IDLE); end
    #1 rst_n = 1'b1;
    cyc(R(0,0,0,4'd0,0,E_IDLE));
    act = {busy, hst, stall, purge};
    checks++;
    if (act !== sb.pop_front()) begin errors++; $display("FAIL reset_after: got %h expected %h", act, E_IDLE); end
  endtask

  task automatic test_branch();
    logic [12:0] act;
    row_t rows[3];
    rows = '{R(1,0,0,4'd0,0,E_FLUSH), R(0,0,0,4'd0,0,E_IDLE), R(0,0,0,4'd0,0,E_IDLE)};
    foreach (rows[i]) begin
      cyc(rows[i]);
      act = {busy, hst, stall, purge};
      checks++;
      if (act !== sb.pop_front()) begin errors++; $display("FAIL branch[%0d]: got %h expected %h", i, act, rows[i].e); end
    end
  endtask

  task automatic test_loaduse();
    logic [12:0] act;
    row_t rows[4];
    rows = '{R(0,1,0,4'd0,0,E_FWD), R(0,0,0,4'd0,0,E_IDLE),
             R(0,1,1,4'd2,0,E_MULTI), R(0,1,0,4'd0,0,E_MULTI)};
    foreach (rows[i]) begin
      cyc(rows[i]);
      act = {busy, hst, stall, purge};
      checks++;
      if (act !== sb.pop_front()) begin errors++; $display("FAIL loaduse[%0d]: got %h expected %h", i, act, rows[i].e); end
    end
    cyc(R(0,0,0,4'd0,0,E_IDLE));
    act = {busy, hst, stall, purge};
    checks++;
    if (act !== sb.pop_front()) begin errors++; $display("FAIL loaduse_end: got %h expected %h", act, E_IDLE); end
  endtask

  task automatic test_multi();
    logic [12:0] act;
    row_t rows[7];
    rows = '{R(0,0,1,4'd3,0,E_MULTI), R(0,0,1,4'd3,0,E_MULTI), R(0,0,0,4'd0,0,E_MULTI),
             R(0,0,0,4'd0,0,E_IDLE),  R(0,0,1,4'd0,0,E_IDLE),  R(0,0,0,4'd0,0,E_IDLE),
             R(0,0,1,4'd1,0,E_MULTI)};
    foreach (rows[i]) begin
      cyc(rows[i]);
      act = {busy, hst, stall, purge};
      checks++;
      if (act !== sb.pop_front()) begin errors++; $display("FAIL multi[%0d]: got %h expected %h", i, act, rows[i].e); end
    end
    cyc(R(0,0,0,4'd0,0,E_IDLE));
    act = {busy, hst, stall, purge};
    checks++;
    if (act !== sb.pop_front()) begin errors++; $display("FAIL multi_len1_end: got %h expected %h", act, E_IDLE); end
    for (int i = 0; i < 16; i++) begin
      cyc(R(0,0,(i == 0),4'hF,0,(i < 15) ? E_MULTI : E_IDLE));
      act = {busy, hst, stall, purge};
      checks++;
      if (act !== sb.pop_front()) begin errors++; $display("FAIL multi_max[%0d]: got %h", i, act); end
    end
  endtask

  task automatic test_memhold();
    logic [12:0] act;
    row_t rows[10];
    rows = '{R(0,0,1,4'd4,0,E_MULTI), R(0,0,0,4'd0,1,E_HOLD), R(0,0,1,4'd9,1,E_HOLD),
             R(0,0,0,4'd0,0,E_MULTI), R(0,0,0,4'd0,0,E_MULTI), R(0,0,0,4'd0,0,E_MULTI),
             R(0,0,0,4'd0,0,E_IDLE),  R(0,1,0,4'd0,1,E_HOLD),  R(0,0,0,4'd0,0,E_IDLE),
             R(1,0,0,4'd0,1,E_FLUSH)};
    foreach (rows[i]) begin
      cyc(rows[i]);
      act = {busy, hst, stall, purge};
      checks++;
      if (act !== sb.pop_front()) begin errors++; $display("FAIL memhold[%0d]: got %h expected %h", i, act, rows[i].e); end
    end
  endtask

  task automatic test_branch_kills_multi();
    logic [12:0] act;
    row_t rows[4];
    do_reset();
    rows = '{R(0,0,1,4'd6,0,E_MULTI), R(1,0,0,4'd0,0,E_FLUSH), R(0,0,0,4'd0,0,E_IDLE),
             R(0,0,0,4'd0,0,E_IDLE)};
    foreach (rows[i]) begin
      cyc(rows[i]);
      act = {busy, hst, stall, purge};
      checks++;
      if (act !== sb.pop_front()) begin errors++; $display("FAIL br_kill[%0d]: got %h expected %h", i, act, rows[i].e); end
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", flush_cnt); end
    checks++;
    if (stall_cyc !== 16'd1) begin errors++; $display("FAIL stall_cycles: got %0d expected 1", stall_cyc); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [12:0] act;
    row_t rows[5];
    rows = '{R(1,0,0,4'd0,0,E_FLUSH), R(1,0,1,4'd2,0,E_FLUSH), R(0,1,0,4'd0,0,E_FWD),
             R(0,1,0,4'd0,0,E_FWD),   R(0,0,0,4'd0,0,E_IDLE)};
    foreach (rows[i]) begin
      cyc(rows[i]);
      act = {busy, hst, stall, purge};
      checks++;
      if (act !== sb.pop_front()) begin errors++; $display("FAIL b2b[%0d]: got %h expected %h", i, act, rows[i].e); end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_loaduse();
    test_multi();
    test_memhold();
    test_branch_kills_multi();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/hazard_controller_n.md
Name: hazard_controller_n

Overview:
- Parametrised pipeline hazard controller for the MIPS core.
- Generalises branch-flush and forwarding-stall handling to N pipe registers with per-register stall/purge vectors.
- Adds multi-cycle EX stalls (mul/div, length-counted) and a global memory-wait hold.
- Sits beside the pipe registers; its vectors drive each register's hold/clear inputs directly.

Parameters:
- STAGES, 5, number of controlled positions: bit 0 = PC/IF, bit k = pipe register k (1 = IF_ID, 2 = ID_EX, 3 = EX_MEM, 4 = MEM_WB).
- BRANCH_STAGE, 3, highest register purged on a taken branch (branch resolves in MEM).
- LOADUSE_STAGE, 2, register that receives the bubble on a forwarding/load-use stall.
- MULTI_STAGE, 2, register holding a multi-cycle op; it and all lower bits stall, the next register is purged.
- CNT_W, 4, width of the multi-cycle length/counter.

Ports:
- ClockInput  input  1  system clock.
- ResetInput_n  input  1  asynchronous active-low reset.
- BranchSignal  input  1  taken branch/jump resolved at BRANCH_STAGE.
- FwdStallRequest  input  1  load-use hazard from the forwarding unit; single-cycle bubble.
- MultiStart  input  1  pulse: multi-cycle op entered MULTI_STAGE.
- MultiLen  input  CNT_W  extra cycles required by that op.
- MemHold  input  1  data/instruction memory not ready.
- StallVector  output  STAGES  bit k = 1: position k holds its contents.
- PurgeVector  output  STAGES  bit k = 1: position k loads a bubble.
- MultiBusy  output  1  multi-cycle stall in progress.
- HazState  output  2  current FSM state code.

Behaviour:
- Inputs are produced on rising edges. Sampling, FSM update and output registering occur on the falling edge of ClockInput. Outputs act at the following rising edge.
- Reset (ResetInput_n = 0, asynchronous):
  - StallVector = 0, PurgeVector = 0, MultiBusy = 0, HazState = IDLE (0).
  - Counter = 0.
  - Takes effect immediately, even mid-stall or mid-flush.
- FSM states: IDLE = 0, FLUSH = 1, MULTI = 2, HOLD = 3.
- Priority on each falling edge, highest first: BranchSignal > MemHold > active/starting multi-cycle > FwdStallRequest > none.
- Branch:
  - Purge bits 1..BRANCH_STAGE. Stall = 0. State FLUSH for this one cycle.
  - Counter cleared and MultiBusy dropped: the older branch kills the younger multi-cycle op.
  - Next edge with no branch re-evaluates from IDLE.
- MemHold:
  - Stall = all ones, Purge = 0, state HOLD.
  - Counter frozen, not decremented.
  - When MemHold deasserts, return to MULTI if counter ≠ 0, else IDLE.
- Multi-cycle:
  - MultiStart with MultiLen = L > 0 in IDLE loads counter = L and enters MULTI.
  - While in MULTI: stall bits 0..MULTI_STAGE, purge bit MULTI_STAGE+1, MultiBusy = 1.
  - Counter decrements each non-hold falling edge. Exactly L stalled cycles result.
  - Leave MULTI when the counter reaches 0.
  - L = 0: no stall.
  - MultiStart while already in MULTI or HOLD is ignored.
  - L = all ones (2^CNT_W − 1) is the maximum; no wrap.
- FwdStallRequest (in IDLE, no higher request):
  - Stall bits 0..LOADUSE_STAGE−1, purge bit LOADUSE_STAGE, for one cycle. State stays IDLE.
  - Ignored while in MULTI: the multi-cycle stall already covers it.
- FwdStallRequest together with MultiStart: multi-cycle wins. The load-use request is re-asserted by the forwarding unit afterwards if still valid.
- Stall and purge are never both set on the same bit.
- Purge bits above STAGES−1 are clipped.
- Elaboration error if BRANCH_STAGE, LOADUSE_STAGE or MULTI_STAGE+1 ≥ STAGES.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds output StallCycles (16 bits): increments each falling edge with any StallVector bit set.
  - Adds output FlushCount (16 bits): increments per branch flush.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: the ports and counters do not exist, and no logic is generated.

Test Plan:
1. Reset low mid-MULTI (counter = 5) → all outputs 0 and HazState = 0 immediately, without waiting for a clock edge.
2. BranchSignal one cycle with defaults → PurgeVector = 5'b01110, StallVector = 0 for one cycle, then both 0.
3. FwdStallRequest one cycle → StallVector = 5'b00011, PurgeVector = 5'b00100 for exactly one cycle.
4. MultiStart with MultiLen = 3 → three cycles of StallVector = 5'b00111, PurgeVector = 5'b01000, MultiBusy = 1; then IDLE. MultiLen = 0 → no stall.
5. MultiLen = 4, MemHold asserted for 2 cycles after the first stall cycle → 2 cycles of StallVector = 5'b11111, then 3 more MULTI cycles (4 total).
6. BranchSignal on the second MULTI cycle (MultiLen = 6) → flush pattern, MultiBusy = 0, IDLE on the next cycle. With HAZARD_STATS_EN defined, FlushCount = 1 and StallCycles = 1.
